// File: rtl/pico_sim.sv
// pico_sim: two-channel query locator sharing one 64-base mismatch-scan engine (optional PICO_SIM_EARLY_EXIT_EN).
// Latency: result valid (ref_len-63)+2 cycles after grant (2 cycles when ref_len<64); grant lands one cycle after WAIT.
// Backpressure: results are held until accepted; a stalled output blocks only its own channel, never the engine.

module pico_sim_chan #(
  parameter int REF_WORDS = 16,
  parameter int RLW       = 11
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_rdy,
  input  logic [127:0]   in_data,
  output logic           out_valid,
  input  logic           out_rdy,
  output logic [127:0]   out_data,
  output logic           waiting,
  input  logic           done,
  input  logic [127:0]   result,
  output logic [RLW-1:0] ref_len,
  output logic [7:0]     max_mm,
  output logic [127:0]   query,
  output logic [15:0]    qidx
);
  localparam int REF_BASES = REF_WORDS * 64;

  typedef enum logic [1:0] {HDR, QRY, WAIT, OUT} state_t;
  state_t state, state_nxt;

  logic        live;
  logic [31:0] qcount;
  logic [31:0] idx;
  logic        in_fire;
  logic        out_fire;
  logic        last_q;

  // live holds rdy low through reset and for the first cycle after it
  assign in_rdy    = live && ((state == HDR) || (state == QRY));
  assign out_valid = (state == OUT);
  assign waiting   = (state == WAIT);
  assign in_fire   = in_valid && in_rdy;
  assign out_fire  = out_valid && out_rdy;
  assign last_q    = ((idx + 32'd1) == qcount);
  assign qidx      = idx[15:0];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= HDR;
    else        state <= state_nxt;
  end

  // Next-state: a zero-query header leaves the channel waiting for another header
  always_comb begin
    state_nxt = state;
    case (state)
      HDR:     if (in_fire && (in_data[95:64] != 32'd0)) state_nxt = QRY;
      QRY:     if (in_fire) state_nxt = WAIT;
      WAIT:    if (done) state_nxt = OUT;
      OUT:     if (out_fire) state_nxt = last_q ? HDR : QRY;
      default: state_nxt = HDR;
    endcase
  end

  // Header, query and result capture; query index advances on each accepted result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live     <= 1'b0;
      qcount   <= '0;
      idx      <= '0;
      ref_len  <= '0;
      max_mm   <= '0;
      query    <= '0;
      out_data <= '0;
    end else begin
      live <= 1'b1;
      if ((state == HDR) && in_fire) begin
        ref_len <= (in_data[127:96] > 32'(REF_BASES)) ? RLW'(REF_BASES) : in_data[96 +: RLW];
        qcount  <= in_data[95:64];
        max_mm  <= in_data[7:0];
        idx     <= '0;
      end
      if ((state == QRY) && in_fire) query <= in_data;
      if ((state == WAIT) && done) out_data <= result;
      if (out_fire) idx <= idx + 32'd1;
    end
  end
endmodule

module pico_sim #(
  parameter int REF_WORDS = 16,
  parameter int REF_AW    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ref_wr_en,
  input  logic [REF_AW-1:0] ref_wr_addr,
  input  logic [127:0]      ref_wr_data,
  input  logic              s1i_valid,
  output logic              s1i_rdy,
  input  logic [127:0]      s1i_data,
  output logic              s1o_valid,
  input  logic              s1o_rdy,
  output logic [127:0]      s1o_data,
  input  logic              s2i_valid,
  output logic              s2i_rdy,
  input  logic [127:0]      s2i_data,
  output logic              s2o_valid,
  input  logic              s2o_rdy,
  output logic [127:0]      s2o_data
);
  localparam int LW  = REF_AW + 6;  // scan location width
  localparam int RLW = REF_AW + 7;  // clamped ref_len width (holds REF_WORDS*64)

  logic [127:0] ref_mem [REF_WORDS];

  logic           w1, w2, d1, d2;
  logic [RLW-1:0] rl1, rl2;
  logic [7:0]     mx1, mx2;
  logic [127:0]   q1, q2;
  logic [15:0]    qi1, qi2;
  logic [127:0]   result;

  pico_sim_chan #(.REF_WORDS(REF_WORDS), .RLW(RLW)) u_ch1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(s1i_valid), .in_rdy(s1i_rdy), .in_data(s1i_data),
    .out_valid(s1o_valid), .out_rdy(s1o_rdy), .out_data(s1o_data),
    .waiting(w1), .done(d1), .result(result),
    .ref_len(rl1), .max_mm(mx1), .query(q1), .qidx(qi1)
  );

  pico_sim_chan #(.REF_WORDS(REF_WORDS), .RLW(RLW)) u_ch2 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(s2i_valid), .in_rdy(s2i_rdy), .in_data(s2i_data),
    .out_valid(s2o_valid), .out_rdy(s2o_rdy), .out_data(s2o_data),
    .waiting(w2), .done(d2), .result(result),
    .ref_len(rl2), .max_mm(mx2), .query(q2), .qidx(qi2)
  );

  // Reference buffer: not reset, writes visible to the very next scan cycle
  always_ff @(posedge clk) begin
    if (ref_wr_en) ref_mem[ref_wr_addr] <= ref_wr_data;
  end

  typedef enum logic [1:0] {E_IDLE, E_SCAN, E_DRAIN, E_DONE} eng_t;
  eng_t eng, eng_nxt;

  logic              owner;   // 1 = stream 2 holds the engine
  logic              last2;   // 1 = stream 2 was served last
  logic              gnt, gnt2;
  logic [RLW-1:0]    g_rl;
  logic [LW-1:0]     nloc_g, nloc, loc, best_loc;
  logic [6:0]        best_mm, mm;
  logic              scan_last;
  logic [REF_AW-1:0] widx, wnxt;
  logic [5:0]        off;
  logic [255:0]      pair;
  logic [6:0]        k;
  logic [127:0]      s_q;
  logic [7:0]        s_max;
  logic [15:0]       s_qi;
  logic              hit;

  // Arbitration: on contention the channel not served last wins
  always_comb begin
    gnt    = w1 || w2;
    gnt2   = w2 && (!w1 || !last2);
    g_rl   = gnt2 ? rl2 : rl1;
    nloc_g = (g_rl >= RLW'(64)) ? LW'(g_rl - RLW'(63)) : '0;
  end

  // Mismatch count of the query against the 64 reference bases starting at loc
  always_comb begin
    s_q   = owner ? q2 : q1;
    widx  = loc[LW-1:6];
    wnxt  = widx + REF_AW'(1);
    off   = loc[5:0];
    pair  = {ref_mem[wnxt], ref_mem[widx]};
    mm    = '0;
    k     = '0;
    for (int i = 0; i < 64; i++) begin
      k = 7'(off) + 7'(i);
      if (pair[{k, 1'b0} +: 2] != s_q[2*i +: 2]) mm = mm + 7'd1;
    end
    scan_last = ((LW+1)'(loc) + (LW+1)'(1)) >= (LW+1)'(nloc);
  end

  // Engine state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) eng <= E_IDLE;
    else        eng <= eng_nxt;
  end

  // Engine sequencing: DRAIN and DONE give the fixed two cycles after the last location
  always_comb begin
    eng_nxt = eng;
    case (eng)
      E_IDLE:  if (gnt) eng_nxt = (nloc_g == '0) ? E_DRAIN : E_SCAN;
      E_SCAN: begin
        if (scan_last) eng_nxt = E_DRAIN;
`ifdef PICO_SIM_EARLY_EXIT_EN
        if (mm == 7'd0) eng_nxt = E_DRAIN;
`else
        // full range always scanned; reported location is the same either way
`endif
      end
      E_DRAIN: eng_nxt = E_DONE;
      E_DONE:  eng_nxt = E_IDLE;
      default: eng_nxt = E_IDLE;
    endcase
  end

  // Grant capture and best-location tracking; strict less-than keeps the lowest L on ties
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner    <= 1'b0;
      last2    <= 1'b1;
      loc      <= '0;
      nloc     <= '0;
      best_mm  <= 7'd64;
      best_loc <= '0;
    end else if ((eng == E_IDLE) && gnt) begin
      owner    <= gnt2;
      last2    <= gnt2;
      loc      <= '0;
      nloc     <= nloc_g;
      best_mm  <= 7'd64;
      best_loc <= '0;
    end else if (eng == E_SCAN) begin
      loc <= loc + LW'(1);
      if (mm < best_mm) begin
        best_mm  <= mm;
        best_loc <= loc;
      end
    end
  end

  // Result word for the owning channel, presented during DONE
  always_comb begin
    s_max  = owner ? mx2 : mx1;
    s_qi   = owner ? qi2 : qi1;
    hit    = (nloc != '0) && ({1'b0, best_mm} <= s_max);
    result = {72'd0, {1'b0, best_mm}, s_qi, hit ? 32'(best_loc) : 32'hFFFF_FFFF};
    d1     = (eng == E_DONE) && !owner;
    d2     = (eng == E_DONE) && owner;
  end
endmodule

// File: tb/tb_pico_sim.sv
// tb_pico_sim: randomized stimulus on both streams checked against a brute-force locator model.
// Expected latency from query acceptance is locations-scanned + 3 for an uncontended engine.
// All waits are bounded; the summary line reports checks and failures.
`timescale 1ns/1ps
module tb_pico_sim;
  localparam int LIMIT = 3000;
`ifdef PICO_SIM_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         ref_wr_en;
  logic [3:0]   ref_wr_addr;
  logic [127:0] ref_wr_data;
  logic         s1i_valid, s1i_rdy, s1o_valid, s1o_rdy;
  logic [127:0] s1i_data, s1o_data;
  logic         s2i_valid, s2i_rdy, s2o_valid, s2o_rdy;
  logic [127:0] s2i_data, s2o_data;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  logic [127:0] refm [16];

  pico_sim dut (
    .clk(clk), .rst_n(rst_n),
    .ref_wr_en(ref_wr_en), .ref_wr_addr(ref_wr_addr), .ref_wr_data(ref_wr_data),
    .s1i_valid(s1i_valid), .s1i_rdy(s1i_rdy), .s1i_data(s1i_data),
    .s1o_valid(s1o_valid), .s1o_rdy(s1o_rdy), .s1o_data(s1o_data),
    .s2i_valid(s2i_valid), .s2i_rdy(s2i_rdy), .s2i_data(s2i_data),
    .s2o_valid(s2o_valid), .s2o_rdy(s2o_rdy), .s2o_data(s2o_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic irdy(input int ch);
    return (ch == 1) ? s1i_rdy : s2i_rdy;
  endfunction
  function automatic logic ovld(input int ch);
    return (ch == 1) ? s1o_valid : s2o_valid;
  endfunction
  function automatic logic [127:0] odat(input int ch);
    return (ch == 1) ? s1o_data : s2o_data;
  endfunction

  function automatic logic [1:0] base(input int kk);
    logic [127:0] w;
    w = refm[kk / 64];
    return w[2*(kk % 64) +: 2];
  endfunction

  function automatic logic [127:0] window(input int L);
    logic [127:0] q;
    q = '0;
    for (int i = 0; i < 64; i++) q[2*i +: 2] = base(L + i);
    return q;
  endfunction

  // Brute force: every location, count differing bases, keep first minimum
  task automatic model(input logic [127:0] q, input logic [31:0] rl_raw, input logic [7:0] mx,
                       input int idx, output logic [127:0] e, output int nscan);
    int rl, best, bl, mm;
    logic [127:0] qq;
    qq = q;
    rl = (rl_raw > 32'd1024) ? 1024 : int'(rl_raw);
    best = 64; bl = 0; nscan = 0;
    for (int L = 0; L + 64 <= rl; L++) begin
      mm = 0;
      for (int i = 0; i < 64; i++) if (base(L + i) != qq[2*i +: 2]) mm++;
      nscan++;
      if (mm < best) begin best = mm; bl = L; end
      if (EARLY && mm == 0) break;
    end
    e = '0;
    e[31:0]  = (rl >= 64 && best <= int'(mx)) ? 32'(bl) : 32'hFFFF_FFFF;
    e[47:32] = 16'(idx);
    e[55:48] = 8'(best);
  endtask

  task automatic wr(input int a, input logic [127:0] d);
    ref_wr_en = 1'b1; ref_wr_addr = 4'(a); ref_wr_data = d;
    tick();
    ref_wr_en = 1'b0;
    refm[a] = d;
  endtask

  task automatic put(input int ch, input logic [127:0] d, output int t);
    int n;
    n = 0;
    if (ch == 1) begin s1i_valid = 1'b1; s1i_data = d; end
    else begin s2i_valid = 1'b1; s2i_data = d; end
    while (!irdy(ch) && n < LIMIT) begin tick(); n++; end
    chk("put_wait", 128'(n < LIMIT), 128'(1));
    tick();
    t = cyc;
    if (ch == 1) s1i_valid = 1'b0; else s2i_valid = 1'b0;
  endtask

  task automatic hdr(input int ch, input logic [31:0] rl, input logic [31:0] qc, input logic [7:0] mx);
    logic [55:0] r;
    int t;
    r = {24'($urandom), $urandom};
    put(ch, {rl, qc, r, mx}, t);
  endtask

  task automatic get(input int ch, input logic [127:0] e, input string tag, input int hold,
                     output int tv, output logic [127:0] got);
    int n;
    logic [127:0] first;
    n = 0;
    while (!ovld(ch) && n < LIMIT) begin tick(); n++; end
    chk({tag, "_wait"}, 128'(n < LIMIT), 128'(1));
    tv = cyc;
    first = odat(ch);
    if (hold > 0) begin
      repeat (hold) tick();
      chk({tag, "_held_vld"}, 128'(ovld(ch)), 128'(1));
      chk({tag, "_held_dat"}, odat(ch), first);
    end
    got = odat(ch);
    chk(tag, got, e);
    if (ch == 1) s1o_rdy = 1'b1; else s2o_rdy = 1'b1;
    tick();
    if (ch == 1) s1o_rdy = 1'b0; else s2o_rdy = 1'b0;
  endtask

  task automatic xact(input int ch, input logic [127:0] q, input logic [31:0] rl, input logic [7:0] mx,
                      input int idx, input string tag, output logic [127:0] got);
    logic [127:0] e;
    int ns, tq, tv;
    model(q, rl, mx, idx, e, ns);
    put(ch, q, tq);
    get(ch, e, tag, 0, tv, got);
    chk({tag, "_lat"}, 128'(tv - tq), 128'(ns + 3));
  endtask

  initial begin
    logic [127:0] g, q, e3;
    int ns, t1v, t1b, t2v, ta;
    rst_n = 1'b0; ref_wr_en = 1'b0; ref_wr_addr = '0; ref_wr_data = '0;
    s1i_valid = 1'b0; s1i_data = '0; s1o_rdy = 1'b0;
    s2i_valid = 1'b0; s2i_data = '0; s2o_rdy = 1'b0;
    repeat (3) tick();
    chk("rst_s1i_rdy", 128'(s1i_rdy), 128'(0));
    chk("rst_s2i_rdy", 128'(s2i_rdy), 128'(0));
    chk("rst_s1o_valid", 128'(s1o_valid), 128'(0));
    chk("rst_s2o_valid", 128'(s2o_valid), 128'(0));
    chk("rst_s1o_data", s1o_data, 128'(0));
    chk("rst_s2o_data", s2o_data, 128'(0));
    rst_n = 1'b1;
    for (int a = 0; a < 16; a++) wr(a, {$urandom, $urandom, $urandom, $urandom});

    // exact copy of word 1 at location 64
    hdr(1, 32'h80, 32'd1, 8'hFF);
    xact(1, refm[1], 32'h80, 8'hFF, 0, "t1", g);
    chk("t1_loc", 128'(g[31:0]), 128'(64));
    chk("t1_mm", 128'(g[55:48]), 128'(0));

    // one-base shift on stream 2
    hdr(2, 32'h80, 32'd1, 8'hFF);
    xact(2, window(1), 32'h80, 8'hFF, 0, "t2", g);
    chk("t2_loc", 128'(g[31:0]), 128'(1));
    chk("t2_mm", 128'(g[55:48]), 128'(0));

    // simultaneous requests; stream 2 output stalled while stream 1 keeps working
    q = window($urandom_range(0, 448));
    model(q, 32'h200, 8'hFF, 0, e3, ns);
    fork
      begin hdr(1, 32'h200, 32'd1, 8'hFF); put(1, q, ta); end
      begin hdr(2, 32'h200, 32'd1, 8'hFF); put(2, q, ta); end
    join
    fork
      begin
        logic [127:0] ga, eb, qb;
        int tqa, nb;
        get(1, e3, "t3_s1", 0, t1v, ga);
        qb = window(5);
        model(qb, 32'h80, 8'hFF, 0, eb, nb);
        hdr(1, 32'h80, 32'd1, 8'hFF);
        put(1, qb, tqa);
        get(1, eb, "t3_s1b", 0, t1b, ga);
      end
      begin
        logic [127:0] gb;
        get(2, e3, "t3_s2", 150, t2v, gb);
      end
    join
    chk("t3_s1_first", 128'(t1v < t2v), 128'(1));
    chk("t3_s1_during_stall", 128'(t1b < t2v + 151), 128'(1));

    // three mismatches at the best location with max_mm = 0
    q = window($urandom_range(0, 448));
    q[20 +: 2]  = q[20 +: 2]  ^ 2'($urandom_range(1, 3));
    q[60 +: 2]  = q[60 +: 2]  ^ 2'($urandom_range(1, 3));
    q[100 +: 2] = q[100 +: 2] ^ 2'($urandom_range(1, 3));
    hdr(1, 32'h200, 32'd1, 8'h00);
    xact(1, q, 32'h200, 8'h00, 0, "t4", g);
    chk("t4_loc", 128'(g[31:0]), 128'(32'hFFFF_FFFF));
    chk("t4_mm", 128'(g[55:48]), 128'(3));

    // two queries in one header, then a short reference
    hdr(2, 32'h100, 32'd2, 8'hFF);
    xact(2, window($urandom_range(0, 192)), 32'h100, 8'hFF, 0, "t5a", g);
    chk("t5a_idx", 128'(g[47:32]), 128'(0));
    xact(2, window($urandom_range(0, 192)), 32'h100, 8'hFF, 1, "t5b", g);
    chk("t5b_idx", 128'(g[47:32]), 128'(1));
    hdr(2, 32'h20, 32'd1, 8'hFF);
    xact(2, window(0), 32'h20, 8'hFF, 0, "t5c", g);
    chk("t5c_loc", 128'(g[31:0]), 128'(32'hFFFF_FFFF));
    chk("t5c_mm", 128'(g[55:48]), 128'(64));

    // zero-query header keeps the channel in header state
    hdr(1, 32'h80, 32'd0, 8'hFF);
    hdr(1, 32'h80, 32'd1, 8'hFF);
    xact(1, window(7), 32'h80, 8'hFF, 0, "t6", g);

    // randomized mix of channels, lengths, thresholds and mutated windows
    for (int it = 0; it < 8; it++) begin
      int ch, rl, rc, qc, L;
      logic [7:0] mx;
      ch = $urandom_range(1, 2);
      rl = $urandom_range(0, 1100);
      rc = (rl > 1024) ? 1024 : rl;
      qc = $urandom_range(1, 2);
      case ($urandom_range(0, 2))
        0:       mx = 8'h00;
        1:       mx = 8'($urandom_range(0, 8));
        default: mx = 8'hFF;
      endcase
      hdr(ch, 32'(rl), 32'(qc), mx);
      for (int j = 0; j < qc; j++) begin
        L = (rc > 64) ? $urandom_range(0, rc - 64) : 0;
        if ($urandom_range(0, 3) == 0) q = {$urandom, $urandom, $urandom, $urandom};
        else q = window(L);
        repeat ($urandom_range(0, 4)) begin
          int p;
          p = $urandom_range(0, 63);
          q[2*p +: 2] = q[2*p +: 2] ^ 2'($urandom_range(1, 3));
        end
        xact(ch, q, 32'(rl), mx, j, "rnd", g);
      end
    end

    // reset in the middle of a long scan
    hdr(1, 32'h400, 32'd1, 8'hFF);
    put(1, window(300), ta);
    repeat (40) tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_s1i_rdy", 128'(s1i_rdy), 128'(0));
    chk("mid_rst_s2i_rdy", 128'(s2i_rdy), 128'(0));
    chk("mid_rst_s1o_valid", 128'(s1o_valid), 128'(0));
    chk("mid_rst_s2o_valid", 128'(s2o_valid), 128'(0));
    tick();
    tick();
    rst_n = 1'b1;
    hdr(1, 32'h100, 32'd1, 8'hFF);
    xact(1, window(100), 32'h100, 8'hFF, 0, "t8", g);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
